noc_mesh_router: RTL and testbench
==================================

// Module: noc_mesh_router
// PURPOSE
//  Parametrised 5-port mesh router (N,S,E,W,L); generalises the fixed corner routers.
//  PORT_EN removes edge ports; per-input FIFOs, XY routing, round-robin output
//  arbitration and credit-based flow control, all inside one block. Single-flit packets.
// PARAMETERS
//  XCOORD      0      router X coordinate (0..15)
//  YCOORD      0      router Y coordinate (0..15)
//  DATA_W      16     flit width; dest X = flit[7:4], dest Y = flit[3:0]; DATA_W >= 8
//  FIFO_DEPTH  4      input FIFO depth per port (>= 2)
//  DOWN_DEPTH  4      downstream buffer depth; initial credit count per output
//  PORT_EN     5'h1F  port enable mask, bit0=N bit1=S bit2=E bit3=W bit4=L (L always 1)
// PORTS
//  clk          in   1          clock
//  rst          in   1          asynchronous reset, active high
//  in_data      in   5*DATA_W   flit per input port; port p at [p*DATA_W +: DATA_W]
//  in_valid     in   5          flit present on in_data[p] this cycle
//  in_credit    out  5          1-cycle pulse: one slot freed in input FIFO p
//  out_data     out  5*DATA_W   flit per output port, registered
//  out_valid    out  5          out_data[p] valid this cycle, registered
//  out_credit   in   5          1-cycle pulse from downstream: one slot freed
//  err_misroute out  1          sticky: flit routed to a disabled port (flit dropped)
//  err_overflow out  1          sticky: write to full FIFO, or credit count over DOWN_DEPTH
// BEHAVIOUR
//  Reset: every output is 0, FIFOs empty, credit counters = DOWN_DEPTH, RR pointers = 0.
//   Asserting rst mid-operation discards all buffered flits; no credits are returned.
//  Disabled port p (PORT_EN[p]=0): in_valid/out_credit ignored; out_valid/in_credit stay 0.
//  Input FIFO: write when in_valid[p]; write to full FIFO drops the flit and sets err_overflow.
//   Simultaneous push and pop on a full FIFO is legal. Head flit is visible one cycle after write.
//  Route (head of FIFO, combinational): dX>XCOORD->E; dX<XCOORD->W; else dY>YCOORD->N;
//   dY<YCOORD->S; else L. A head flit routed to a disabled port is popped and dropped the same
//   cycle. It sets err_misroute and returns an in_credit.
//  Arbitration per output o: requesters = non-empty inputs whose head routes to o. An input
//   may request its own port (U-turn); this is legal.
//   Grant only if credit_cnt[o] > 0. Round-robin: search starts at rr_ptr[o], ascending
//   index mod 5. After a grant, rr_ptr[o] = winner+1 mod 5. No grant leaves rr_ptr unchanged.
//   An input wins at most one output per cycle, because each head has one route.
//  Grant in cycle t: FIFO pops at t; out_data/out_valid registered at t+1; in_credit[p] pulses
//   at t+1. Minimum latency: in_valid at t -> out_valid at t+2.
//  Credit counter: width $clog2(DOWN_DEPTH+1).
//   Grant only: counter -1. out_credit only: counter +1. Both in the same cycle: unchanged.
//   An increment at DOWN_DEPTH saturates and sets err_overflow.
//  out_valid is a 1-cycle pulse per flit. Back-to-back flits on one output are allowed every cycle.
//  err_* bits clear only on reset.
// TESTING
//  X=1,Y=1, L injects 0x0021 -> out_valid[E]=1 at cycle+2 with 0x0021; in_credit[L] pulses at cycle+2.
//  N,W,L all send dest 0x11 (local) the same cycle -> L outputs N, W, L order on 3 consecutive cycles.
//  Only E enabled for downstream, no out_credit, 5 flits to E -> 4 sent; the 5th stays queued.
//   After one out_credit pulse, the 5th flit is sent 2 cycles later.
//  PORT_EN=5'h19, flit needing S -> dropped; err_misroute=1; in_credit pulses; nothing on outputs.
//  5 writes to L without pops (E starved) -> 5th dropped, err_overflow=1; assert rst -> all
//   outputs 0 and credits back at 4.
//  out_credit[E] with a grant to E in the same cycle -> counter unchanged (check at 2 -> 2).

Source files
------------

// File: rtl/noc_mesh_router_if.sv
// Flit, credit and error signals between a mesh router and its five neighbours.
// master drives flits/credits into the router; slave is the router itself.
interface noc_mesh_router_if #(
  parameter int DATA_W = 16
);
  logic [5*DATA_W-1:0] in_data;
  logic [4:0]          in_valid;
  logic [4:0]          in_credit;
  logic [5*DATA_W-1:0] out_data;
  logic [4:0]          out_valid;
  logic [4:0]          out_credit;
  logic                err_misroute;
  logic                err_overflow;

  modport master (
    output in_data, in_valid, out_credit,
    input  in_credit, out_data, out_valid, err_misroute, err_overflow
  );

  modport slave (
    input  in_data, in_valid, out_credit,
    output in_credit, out_data, out_valid, err_misroute, err_overflow
  );
endinterface

// File: rtl/noc_mesh_router.sv
// Five-port (N,S,E,W,L) single-flit mesh router: per-input FIFOs, XY routing,
// round-robin output arbitration and credit-based downstream flow control.
module noc_mesh_router #(
  parameter int         XCOORD     = 0,
  parameter int         YCOORD     = 0,
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter int         DOWN_DEPTH = 4,
  parameter logic [4:0] PORT_EN    = 5'h1F
) (
  input  logic               clk,
  input  logic               rst,
  noc_mesh_router_if.slave   bus
);

  typedef enum logic [2:0] {P_N = 3'd0, P_S = 3'd1, P_E = 3'd2, P_W = 3'd3, P_L = 3'd4} port_e;

  localparam int         PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int         CR_W  = $clog2(DOWN_DEPTH + 1);
  localparam logic [4:0] EN    = PORT_EN | 5'h10;
  localparam logic [3:0] MY_X  = 4'(XCOORD);
  localparam logic [3:0] MY_Y  = 4'(YCOORD);

  logic [DATA_W-1:0]           mem_q [5][FIFO_DEPTH];
  logic [4:0][PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [4:0][CR_W-1:0]        credit_q, credit_d;
  logic [4:0][2:0]             rr_q, rr_d;
  logic [4:0][DATA_W-1:0]      out_data_q, out_data_d;
  logic [4:0]                  out_valid_q, out_valid_d;
  logic [4:0]                  in_credit_q, in_credit_d;
  logic                        err_misroute_q, err_misroute_d;
  logic                        err_overflow_q, err_overflow_d;

  logic [4:0][DATA_W-1:0]      head;
  port_e                       route [5];
  logic [4:0]                  nonempty, drop, pop, accept;
  logic [4:0][4:0]             gnt;
  logic                        found;
  logic [2:0]                  idx;

  // Head-of-line routing: X first, then Y, else deliver locally.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      head[p]     = mem_q[p][rd_ptr_q[p]];
      nonempty[p] = EN[p] && (cnt_q[p] != '0);
      if (head[p][7:4] > MY_X)      route[p] = P_E;
      else if (head[p][7:4] < MY_X) route[p] = P_W;
      else if (head[p][3:0] > MY_Y) route[p] = P_N;
      else if (head[p][3:0] < MY_Y) route[p] = P_S;
      else                          route[p] = P_L;
      drop[p] = nonempty[p] && !EN[route[p]];
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    gnt         = '0;
    rr_d        = rr_q;
    out_valid_d = '0;
    out_data_d  = '0;
    found       = 1'b0;
    idx         = '0;
    for (int o = 0; o < 5; o++) begin
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
        idx = (int'(rr_q[o]) + i >= 5) ? 3'(int'(rr_q[o]) + i - 5) : 3'(int'(rr_q[o]) + i);
        if (!found && EN[o] && (credit_q[o] != '0) && nonempty[idx] && !drop[idx]
            && (route[idx] == port_e'(o))) begin
          found          = 1'b1;
          gnt[o][idx]    = 1'b1;
          out_valid_d[o] = 1'b1;
          out_data_d[o]  = head[idx];
          rr_d[o]        = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    pop            = '0;
    accept         = '0;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    credit_d       = credit_q;
    in_credit_d    = '0;
    err_misroute_d = err_misroute_q | (|drop);
    err_overflow_d = err_overflow_q;

    for (int p = 0; p < 5; p++) begin
      pop[p] = drop[p] | gnt[0][p] | gnt[1][p] | gnt[2][p] | gnt[3][p] | gnt[4][p];
      // A full FIFO still accepts a write in the cycle its head leaves.
      if (EN[p] && bus.in_valid[p]) begin
        if ((cnt_q[p] != CNT_W'(FIFO_DEPTH)) || pop[p]) accept[p] = 1'b1;
        else                                            err_overflow_d = 1'b1;
      end
      if (accept[p])
        wr_ptr_d[p] = (wr_ptr_q[p] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q[p] + 1'b1;
      if (pop[p])
        rd_ptr_d[p] = (rd_ptr_q[p] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q[p] + 1'b1;
      case ({accept[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + 1'b1;
        2'b01:   cnt_d[p] = cnt_q[p] - 1'b1;
        default: cnt_d[p] = cnt_q[p];
      endcase
      in_credit_d[p] = pop[p];
    end

    for (int o = 0; o < 5; o++) begin
      if (EN[o] && bus.out_credit[o] && !(|gnt[o])) begin
        if (credit_q[o] == CR_W'(DOWN_DEPTH)) err_overflow_d = 1'b1;
        else                                  credit_d[o] = credit_q[o] + 1'b1;
      end else if (!(EN[o] && bus.out_credit[o]) && (|gnt[o])) begin
        credit_d[o] = credit_q[o] - 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      credit_q       <= {5{CR_W'(DOWN_DEPTH)}};
      rr_q           <= '0;
      out_data_q     <= '0;
      out_valid_q    <= '0;
      in_credit_q    <= '0;
      err_misroute_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      credit_q       <= credit_d;
      rr_q           <= rr_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      in_credit_q    <= in_credit_d;
      err_misroute_q <= err_misroute_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy counters alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (accept[p]) mem_q[p][wr_ptr_q[p]] <= bus.in_data[p*DATA_W +: DATA_W];
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.in_credit    = in_credit_q;
  assign bus.err_misroute = err_misroute_q;
  assign bus.err_overflow = err_overflow_q;

endmodule

// File: tb/tb_noc_mesh_router.sv
// Directed bench for noc_mesh_router: two instances (full and edge-trimmed ports)
// at X=1,Y=1, with a scoreboard of expected output flits per instance.
module tb_noc_mesh_router;

  localparam int DW = 16;

  typedef struct {
    int          port;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  noc_mesh_router_if #(.DATA_W(DW)) b0 ();
  noc_mesh_router_if #(.DATA_W(DW)) b1 ();

  noc_mesh_router #(.XCOORD(1), .YCOORD(1), .DATA_W(DW), .FIFO_DEPTH(4),
                    .DOWN_DEPTH(4), .PORT_EN(5'h1F))
    dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  noc_mesh_router #(.XCOORD(1), .YCOORD(1), .DATA_W(DW), .FIFO_DEPTH(4),
                    .DOWN_DEPTH(4), .PORT_EN(5'h19))
    dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b0.in_data = '0; b0.in_valid = '0; b0.out_credit = '0;
    b1.in_data = '0; b1.in_valid = '0; b1.out_credit = '0;
  endtask

  task automatic send0(input int p, input logic [15:0] d);
    b0.in_data[p*DW +: DW] = d;
    b0.in_valid[p]         = 1'b1;
  endtask

  task automatic expect0(input int p, input logic [15:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    q0.push_back(e);
  endtask

  // Scoreboard: every output flit must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      for (int o = 0; o < 5; o++) begin
        if (b0.out_valid[o]) begin
          if (q0.size() == 0) check("dut0_spurious_port", o, 32'hFFFF_FFFF);
          else begin
            e = q0.pop_front();
            check("dut0_port", o, e.port);
            check("dut0_data", 32'(b0.out_data[o*DW +: DW]), 32'(e.data));
          end
        end
        if (b1.out_valid[o]) begin
          if (q1.size() == 0) check("dut1_spurious_port", o, 32'hFFFF_FFFF);
          else begin
            e = q1.pop_front();
            check("dut1_port", o, e.port);
            check("dut1_data", 32'(b1.out_data[o*DW +: DW]), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    check("rst_out_valid", 32'(b0.out_valid), 32'h0);
    check("rst_in_credit", 32'(b0.in_credit), 32'h0);
    check("rst_out_data", 32'(b0.out_data[2*DW +: DW]), 32'h0);
    check("rst_errs", 32'({b0.err_misroute, b0.err_overflow}), 32'h0);
    check("rst_credit_E", 32'(dut0.credit_q[2]), 32'd4);
    tick(); tick();
    rst = 1'b0;
    tick();

    // L -> E single flit, two-cycle latency
    send0(4, 16'h0021);
    expect0(2, 16'h0021);
    tick();
    clear_inputs();
    check("lat_credit_early", 32'(b0.in_credit), 32'h0);
    check("lat_valid_early", 32'(b0.out_valid), 32'h0);
    tick();
    check("lat_valid_E", 32'(b0.out_valid), 32'h04);
    check("lat_credit_L", 32'(b0.in_credit), 32'h10);
    check("credit_E_dec", 32'(dut0.credit_q[2]), 32'd3);
    b0.out_credit[2] = 1'b1;
    tick();
    clear_inputs();
    check("credit_E_ret", 32'(dut0.credit_q[2]), 32'd4);
    check("lat_credit_pulse", 32'(b0.in_credit), 32'h0);

    // N, W, L contend for L: round-robin from pointer 0
    send0(0, 16'h0111);
    send0(3, 16'h0311);
    send0(4, 16'h0411);
    expect0(4, 16'h0111);
    expect0(4, 16'h0311);
    expect0(4, 16'h0411);
    tick();
    clear_inputs();
    tick();
    check("rr_first_valid", 32'(b0.out_valid), 32'h10);
    tick(); tick(); tick();
    b0.out_credit[4] = 1'b1;
    tick(); tick(); tick();
    clear_inputs();
    check("credit_L_ret", 32'(dut0.credit_q[4]), 32'd4);

    // Five flits to E with no downstream credit returned: only four leave
    for (int i = 0; i < 5; i++) begin
      send0(4, 16'((i + 1) * 16'h1000 + 16'h0021));
      if (i < 4) expect0(2, 16'((i + 1) * 16'h1000 + 16'h0021));
      tick();
    end
    clear_inputs();
    repeat (6) tick();
    check("starve_credit_E", 32'(dut0.credit_q[2]), 32'd0);
    check("starve_queued", 32'(q0.size()), 32'd0);
    b0.out_credit[2] = 1'b1;
    expect0(2, 16'h5021);
    tick();
    clear_inputs();
    check("resume_early", 32'(b0.out_valid), 32'h0);
    tick();
    check("resume_valid_E", 32'(b0.out_valid), 32'h04);
    check("resume_credit_E", 32'(dut0.credit_q[2]), 32'd0);
    tick();

    // E starved: fifth write to L overflows
    check("ovf_before", 32'(b0.err_overflow), 32'h0);
    for (int i = 0; i < 5; i++) begin
      send0(4, 16'((i + 6) * 16'h1000 + 16'h0021));
      tick();
      if (i == 3) check("ovf_at_full", 32'(b0.err_overflow), 32'h0);
    end
    clear_inputs();
    check("ovf_set", 32'(b0.err_overflow), 32'h1);
    tick();
    check("ovf_sticky", 32'(b0.err_overflow), 32'h1);

    rst = 1'b1;
    #2;
    check("rst2_errs", 32'({b0.err_misroute, b0.err_overflow}), 32'h0);
    check("rst2_out_valid", 32'(b0.out_valid), 32'h0);
    check("rst2_credit_E", 32'(dut0.credit_q[2]), 32'd4);
    check("rst2_credit_N", 32'(dut0.credit_q[0]), 32'd4);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst2_flushed", 32'(b0.out_valid | b0.in_credit), 32'h0);

    // Grant and out_credit on E in the same cycle leave the counter alone
    send0(4, 16'h0B21); expect0(2, 16'h0B21);
    tick();
    send0(4, 16'h0C21); expect0(2, 16'h0C21);
    tick();
    clear_inputs();
    tick(); tick();
    check("both_pre_credit", 32'(dut0.credit_q[2]), 32'd2);
    send0(4, 16'h0D21); expect0(2, 16'h0D21);
    tick();
    clear_inputs();
    b0.out_credit[2] = 1'b1;
    tick();
    clear_inputs();
    check("both_credit_E", 32'(dut0.credit_q[2]), 32'd2);
    check("both_valid_E", 32'(b0.out_valid), 32'h04);

    // Credit returned above DOWN_DEPTH saturates and flags overflow
    check("cr_ovf_before", 32'(b0.err_overflow), 32'h0);
    b0.out_credit[0] = 1'b1;
    tick();
    clear_inputs();
    check("cr_ovf_set", 32'(b0.err_overflow), 32'h1);
    check("cr_ovf_sat", 32'(dut0.credit_q[0]), 32'd4);

    // Edge router (S,E disabled): flit needing S is dropped
    check("mis_before", 32'(b1.err_misroute), 32'h0);
    b1.in_data[4*DW +: DW] = 16'h0010;
    b1.in_valid[4] = 1'b1;
    tick();
    clear_inputs();
    check("mis_credit_early", 32'(b1.in_credit), 32'h0);
    tick();
    check("mis_flag", 32'(b1.err_misroute), 32'h1);
    check("mis_credit_L", 32'(b1.in_credit), 32'h10);
    check("mis_no_out", 32'(b1.out_valid), 32'h0);
    b1.in_data[2*DW +: DW] = 16'h0011;
    b1.in_valid[2] = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();
    check("dis_in_ignored", 32'(b1.in_credit | b1.out_valid), 32'h0);
    check("mis_sticky", 32'(b1.err_misroute), 32'h1);

    repeat (4) tick();
    check("dut0_leftover", 32'(q0.size()), 32'd0);
    check("dut1_leftover", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
